piso_n: RTL and testbench

- Parallel-in, serial-out transmitter: captures an N-bit word on `load` and shifts it out one bit per clock, with valid/last/done framing.
- Serial-side counterpart to the team's N-bit loadable register: takes a word held in `reg_n` and streams it onto a 1-bit link.
- Intended for driving serial links and test streams.

---
 rtl/piso_n.sv | 126 ++++++++++++
 tb/tb_piso_n.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_n.sv
// Parallel-in serial-out transmitter with valid/last/done framing.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_n #(
  parameter int N         = 32,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] in_data,
  output logic         ready,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         last,
  output logic         done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
  logic par_q, par_d;
`else
  localparam bit PAR_EN = 1'b0;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sh_q, sh_d;
  logic          ser_out_d, ser_valid_d;
  logic          last_d, done_d;

  assign ready = (state_q == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      last      <= 1'b0;
      done      <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      ser_out   <= ser_out_d;
      ser_valid <= ser_valid_d;
      last      <= last_d;
      done      <= done_d;
`ifdef PISO_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // Outputs are computed one cycle ahead so every output leaves a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    last_d      = 1'b0;
    done_d      = 1'b0;
`ifdef PISO_PARITY_EN
    par_d       = par_q;
`endif
    unique case (1'b1)
      (state_q == IDLE): begin
        if (load) begin
          state_d     = SHIFT;
          cnt_d       = '0;
          ser_valid_d = 1'b1;
          ser_out_d   = LSB_FIRST ? in_data[0] : in_data[N-1];
          sh_d        = LSB_FIRST ? (in_data >> 1) : (in_data << 1);
          last_d      = (N == 1) && !PAR_EN;
`ifdef PISO_PARITY_EN
          par_d       = ^in_data;
`endif
        end
      end
      (state_q == SHIFT): begin
        if (cnt_q == LAST_IDX) begin
`ifdef PISO_PARITY_EN
          state_d     = PARITY;
          ser_valid_d = 1'b1;
          ser_out_d   = par_q;
          last_d      = 1'b1;
`else
          state_d     = IDLE;
          done_d      = 1'b1;
`endif
        end else begin
          cnt_d       = cnt_q + 1'b1;
          ser_valid_d = 1'b1;
          ser_out_d   = LSB_FIRST ? sh_q[0] : sh_q[N-1];
          sh_d        = LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);
          last_d      = !PAR_EN && (cnt_d == LAST_IDX);
        end
      end
`ifdef PISO_PARITY_EN
      (state_q == PARITY): begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_n.sv
// Directed bench for piso_n: LSB/MSB instances at N=8 plus an N=1 instance.
// Expected frames follow PISO_PARITY_EN when the macro is defined.
module tb_piso_n;

  localparam int N = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = N + 1;
`else
  localparam int FL = N;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic       load1 = 1'b0;
  logic [7:0] in_data = '0;
  logic [0:0] in1 = '0;

  logic l_ready, l_out, l_valid, l_last, l_done;
  logic m_ready, m_out, m_valid, m_last, m_done;
  logic s_ready, s_out, s_valid, s_last, s_done;

  int ncomp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  piso_n #(.N(N), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .reset(reset), .load(load), .in_data(in_data),
    .ready(l_ready), .ser_out(l_out), .ser_valid(l_valid),
    .last(l_last), .done(l_done)
  );

  piso_n #(.N(N), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .reset(reset), .load(load), .in_data(in_data),
    .ready(m_ready), .ser_out(m_out), .ser_valid(m_valid),
    .last(m_last), .done(m_done)
  );

  piso_n #(.N(1), .LSB_FIRST(1'b1)) dut_s (
    .clk(clk), .reset(reset), .load(load1), .in_data(in1),
    .ready(s_ready), .ser_out(s_out), .ser_valid(s_valid),
    .last(s_last), .done(s_done)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, ".l_ready"}, l_ready, 1'b1);
    chk({tag, ".l_valid"}, l_valid, 1'b0);
    chk({tag, ".l_out"}, l_out, 1'b0);
    chk({tag, ".l_last"}, l_last, 1'b0);
    chk({tag, ".l_done"}, l_done, exp_done);
    chk({tag, ".m_ready"}, m_ready, 1'b1);
    chk({tag, ".m_valid"}, m_valid, 1'b0);
    chk({tag, ".m_done"}, m_done, exp_done);
    chk({tag, ".s_ready"}, s_ready, 1'b1);
    chk({tag, ".s_valid"}, s_valid, 1'b0);
    chk({tag, ".s_done"}, s_done, 1'b0);
  endtask

  // Entered in the cycle of bit 0; leaves in the done cycle.
  task automatic run_frame(input string tag, input logic [7:0] w,
                           input int pulse_at, input logic [7:0] pdata,
                           input logic nload, input logic [7:0] ndata);
    for (int k = 0; k < FL; k++) begin
      logic eb, mb;
      eb = (k < N) ? w[k] : ^w;
      mb = (k < N) ? w[N-1-k] : ^w;
      chk({tag, ".l_valid"}, l_valid, 1'b1);
      chk({tag, ".l_bit"}, l_out, eb);
      chk({tag, ".l_last"}, l_last, k == FL - 1);
      chk({tag, ".l_ready"}, l_ready, 1'b0);
      chk({tag, ".l_done"}, l_done, 1'b0);
      chk({tag, ".m_valid"}, m_valid, 1'b1);
      chk({tag, ".m_bit"}, m_out, mb);
      chk({tag, ".m_last"}, m_last, k == FL - 1);
      if (k == pulse_at) begin
        load = 1'b1;
        in_data = pdata;
      end else if (k == pulse_at + 1) begin
        load = 1'b0;
      end
      if (k == FL - 1) begin
        load = nload;
        in_data = ndata;
      end
      tick();
    end
    chk_idle({tag, ".done"}, 1'b1);
  endtask

  initial begin
    #1;
    reset = 1'b1;
    load = 1'b1;
    in_data = 8'hFF;
    #1 chk_idle("rst_async", 1'b0);
    tick();
    chk_idle("rst_c1", 1'b0);
    tick();
    chk_idle("rst_c2", 1'b0);
    load = 1'b0;
    reset = 1'b0;
    tick();
    chk_idle("post_rst", 1'b0);

    load = 1'b1;
    in_data = 8'h0F;
    tick();
    load = 1'b0;
    run_frame("f0F", 8'h0F, 100, 8'h00, 1'b0, 8'h00);
    tick();
    chk_idle("f0F.after", 1'b0);

    load = 1'b1;
    in_data = 8'h0F;
    tick();
    load = 1'b0;
    run_frame("ign", 8'h0F, 3, 8'hFF, 1'b1, 8'h01);
    tick();
    run_frame("b2b1", 8'h01, 100, 8'h00, 1'b1, 8'h02);
    tick();
    run_frame("b2b2", 8'h02, 100, 8'h00, 1'b0, 8'h00);
    tick();
    chk_idle("b2b.after", 1'b0);

    load = 1'b1;
    in_data = 8'hAA;
    tick();
    load = 1'b0;
    in_data = 8'h00;
    repeat (4) tick();
    chk("mid.valid", l_valid, 1'b1);
    chk("mid.ready", l_ready, 1'b0);
    chk("mid.m_bit", m_out, 1'b1);
    #2 reset = 1'b1;
    #1 chk_idle("rst_mid", 1'b0);
    tick();
    reset = 1'b0;
    tick();
    chk_idle("rst_mid.rel", 1'b0);
    load = 1'b1;
    in_data = 8'h81;
    tick();
    load = 1'b0;
    run_frame("f81", 8'h81, 100, 8'h00, 1'b0, 8'h00);
    tick();

    load = 1'b1;
    in_data = 8'h07;
    tick();
    load = 1'b0;
    run_frame("f07", 8'h07, 100, 8'h00, 1'b0, 8'h00);
    tick();
    load = 1'b1;
    in_data = 8'h03;
    tick();
    load = 1'b0;
    run_frame("f03", 8'h03, 100, 8'h00, 1'b0, 8'h00);
    tick();
    chk_idle("f03.after", 1'b0);

    load1 = 1'b1;
    in1 = 1'b1;
    tick();
    load1 = 1'b0;
    chk("n1.valid", s_valid, 1'b1);
    chk("n1.bit", s_out, 1'b1);
    chk("n1.ready", s_ready, 1'b0);
`ifdef PISO_PARITY_EN
    chk("n1.last", s_last, 1'b0);
    tick();
    chk("n1.par_valid", s_valid, 1'b1);
    chk("n1.par_bit", s_out, 1'b1);
    chk("n1.par_last", s_last, 1'b1);
`else
    chk("n1.last", s_last, 1'b1);
`endif
    tick();
    chk("n1.done", s_done, 1'b1);
    chk("n1.done_ready", s_ready, 1'b1);
    chk("n1.done_valid", s_valid, 1'b0);
    tick();
    chk("n1.done_clr", s_done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
